// File: rtl/cordic_axi_lite_slave.sv
// cordic_axi_lite_slave: AXI4-Lite register slave driving the CORDIC core start/done handshake.
// Define CORDIC_IRQ_EN to add the registered irq output (CTRL.irq_en && STATUS.done).
module cordic_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int RES_W = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_angle,
  output logic                            core_mode,
  input  logic                            core_done,
  input  logic [RES_W-1:0]                core_sin,
  input  logic [RES_W-1:0]                core_cos
`ifdef CORDIC_IRQ_EN
  ,
  output logic                            irq
`endif
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  logic aw_ready_q, aw_ready_d, bvalid_q, bvalid_d, ar_ready_q, ar_ready_d, rvalid_q, rvalid_d;
  logic start_q, start_d, mode_q, mode_d, irq_en_q, irq_en_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d, angle_q, angle_d, result_q, result_d;
  logic wr_en, rd_en, wr_ctrl, wr_stat, start_wr, accept, cmpl;
  logic [15:0] sin16, cos16;
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  always_comb begin
    wr_en = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
    rd_en = ar_ready_q && S_AXI_ARVALID;
    wr_ctrl = wr_en && S_AXI_AWADDR[3:2] == 2'd0 && S_AXI_WSTRB[0];
    wr_stat = wr_en && S_AXI_AWADDR[3:2] == 2'd3 && S_AXI_WSTRB[0];
    cmpl = core_done && busy_q;
    start_wr = wr_ctrl && S_AXI_WDATA[0];
    // a completion on the same edge frees the core, so the start is still taken
    accept = start_wr && (!busy_q || core_done);
    sin16 = 16'($signed(core_sin));
    cos16 = 16'($signed(core_cos));
    aw_ready_d = S_AXI_AWVALID && S_AXI_WVALID && !aw_ready_q && !bvalid_q;
    bvalid_d = wr_en || (bvalid_q && !S_AXI_BREADY);
    ar_ready_d = S_AXI_ARVALID && !ar_ready_q && !rvalid_q;
    rvalid_d = rd_en || (rvalid_q && !S_AXI_RREADY);
    rdata_d = !rd_en ? rdata_q :
              S_AXI_ARADDR[3:2] == 2'd0 ? DW'({irq_en_q, mode_q, 1'b0}) :
              S_AXI_ARADDR[3:2] == 2'd1 ? angle_q :
              S_AXI_ARADDR[3:2] == 2'd2 ? result_q : DW'({err_q, done_q, busy_q});
    start_d = accept;
    mode_d = wr_ctrl ? S_AXI_WDATA[1] : mode_q;
    irq_en_d = wr_ctrl ? S_AXI_WDATA[2] : irq_en_q;
    busy_d = accept || (busy_q && !cmpl);
    done_d = cmpl || (done_q && !(wr_stat && S_AXI_WDATA[1]));
    err_d = (start_wr && busy_q && !core_done) || (err_q && !(wr_stat && S_AXI_WDATA[2]));
    result_d = cmpl ? DW'({sin16, cos16}) : result_q;
    angle_d = angle_q;
    for (int i = 0; i < DW/8; i++)
      if (wr_en && S_AXI_AWADDR[3:2] == 2'd1 && S_AXI_WSTRB[i]) angle_d[8*i +: 8] = S_AXI_WDATA[8*i +: 8];
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      {aw_ready_q, bvalid_q, ar_ready_q, rvalid_q, start_q, mode_q, irq_en_q, busy_q, done_q, err_q} <= '0;
      rdata_q <= '0;
      angle_q <= '0;
      result_q <= '0;
    end else begin
      {aw_ready_q, bvalid_q, ar_ready_q, rvalid_q} <= {aw_ready_d, bvalid_d, ar_ready_d, rvalid_d};
      {start_q, mode_q, irq_en_q, busy_q, done_q, err_q} <= {start_d, mode_d, irq_en_d, busy_d, done_d, err_d};
      rdata_q <= rdata_d;
      angle_q <= angle_d;
      result_q <= result_d;
    end
  end
`ifdef CORDIC_IRQ_EN
  logic irq_q;
  always_ff @(posedge S_AXI_ACLK) irq_q <= S_AXI_ARESETN && irq_en_d && done_d;
  assign irq = irq_q;
`endif
  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY = aw_ready_q;
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = 2'b00;
  assign S_AXI_RVALID = rvalid_q;
  assign core_start = start_q;
  assign core_angle = angle_q;
  assign core_mode = mode_q;
endmodule

// File: tb/tb_cordic_axi_lite_slave.sv
// tb_cordic_axi_lite_slave: randomized and directed checks of the CORDIC AXI4-Lite slave
// against a register-level model of the map and start/done/err rules.
module tb_cordic_axi_lite_slave;
  logic clk = 0, rstn = 0;
  logic [3:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid, core_start, core_mode;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, core_angle;
  logic core_done = 0;
  logic [15:0] core_sin = 0, core_cos = 0;
`ifdef CORDIC_IRQ_EN
  logic irq;
`endif
  int n_cmp = 0, n_err = 0;
  logic m_mode, m_irq_en, m_busy, m_done, m_err;
  logic [31:0] m_angle, m_result;

  always #5 clk = ~clk;

  cordic_axi_lite_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_start(core_start), .core_angle(core_angle), .core_mode(core_mode),
    .core_done(core_done), .core_sin(core_sin), .core_cos(core_cos)
`ifdef CORDIC_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic model_reset;
    {m_mode, m_irq_en, m_busy, m_done, m_err} = '0;
    m_angle = 0;
    m_result = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return {29'd0, m_irq_en, m_mode, 1'b0};
      2'd1: return m_angle;
      2'd2: return m_result;
      default: return {29'd0, m_err, m_done, m_busy};
    endcase
  endfunction

  // Effect of one accepted write, with an optional core_done on the same edge.
  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic dn, input logic [15:0] sn, input logic [15:0] cs, output logic st);
    logic dset, eset;
    dset = 0; eset = 0; st = 0;
    if (dn && m_busy) begin m_result = {sn, cs}; m_busy = 0; dset = 1; end
    case (a[3:2])
      2'd0: if (s[0]) begin
        m_mode = d[1]; m_irq_en = d[2];
        if (d[0]) begin
          if (m_busy) eset = 1;
          else begin st = 1; m_busy = 1; end
        end
      end
      2'd1: for (int i = 0; i < 4; i++) if (s[i]) m_angle[8*i +: 8] = d[8*i +: 8];
      2'd3: if (s[0]) begin
        if (d[1]) m_done = 0;
        if (d[2]) m_err = 0;
      end
      default: ;
    endcase
    m_done = m_done | dset;
    m_err = m_err | eset;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic dn, input logic [15:0] sn, input logic [15:0] cs, input string tag);
    logic exp_st;
    int t;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    t = 0;
    while (!(awready && wready) && t < 20) begin @(posedge clk); #1; t++; end
    if (!(awready && wready)) begin
      n_cmp++; n_err++;
      $display("FAIL %s aw_timeout awready=%b wready=%b required 1", tag, awready, wready);
      awvalid = 0; wvalid = 0;
      return;
    end
    if (dn) begin core_done = 1; core_sin = sn; core_cos = cs; end
    model_write(a, d, s, dn, sn, cs, exp_st);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; core_done = 0;
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || core_start !== exp_st || core_mode !== m_mode) begin
      n_err++;
      $display("FAIL %s bresp bvalid=%b bresp=%b awready=%b start=%b mode=%b required 1/00/0/%b/%b",
               tag, bvalid, bresp, awready, core_start, core_mode, exp_st, m_mode);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bvalid !== 1'b0 || core_start !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_b bvalid=%b start=%b required 0/0", tag, bvalid, core_start);
    end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, input string tag);
    int t;
    d = 'x;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    t = 0;
    while (!arready && t < 20) begin @(posedge clk); #1; t++; end
    if (!arready) begin
      n_cmp++; n_err++;
      $display("FAIL %s ar_timeout arready=%b required 1", tag, arready);
      arvalid = 0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 0;
    d = rdata;
    n_cmp++;
    if (rvalid !== 1'b1 || rresp !== 2'b00) begin
      n_err++;
      $display("FAIL %s rvalid=%b rresp=%b required 1/00", tag, rvalid, rresp);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_read(input logic [3:0] a, input string tag);
    logic [31:0] d, e;
    e = model_read(a);
    axi_read(a, d, tag);
    n_cmp++;
    if (d !== e) begin
      n_err++;
      $display("FAIL %s addr=%h rdata=%h required %h", tag, a, d, e);
    end
  endtask

  task automatic core_pulse(input logic [15:0] sn, input logic [15:0] cs);
    @(posedge clk); #1;
    core_done = 1; core_sin = sn; core_cos = cs;
    if (m_busy) begin m_result = {sn, cs}; m_busy = 0; m_done = 1; end
    @(posedge clk); #1;
    core_done = 0;
  endtask

  task automatic test_reset;
    rstn = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if ({bvalid, rvalid, awready, arready, core_start, core_mode} !== 6'b0 || core_angle !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs bvalid=%b rvalid=%b awready=%b arready=%b start=%b mode=%b angle=%h required all 0",
               bvalid, rvalid, awready, arready, core_start, core_mode, core_angle);
    end
    rstn = 1;
    for (int a = 0; a < 16; a += 4) check_read(4'(a), "reset_read");
  endtask

  task automatic test_angle;
    axi_write(4'h4, 32'hDEAD0011, 4'b0011, 0, 0, 0, "angle_wr");
    check_read(4'h4, "angle_rd");
    n_cmp++;
    if (core_angle !== m_angle) begin
      n_err++;
      $display("FAIL core_angle got=%h required %h", core_angle, m_angle);
    end
  endtask

  task automatic test_start;
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0, "start_wr");
    check_read(4'hC, "start_status_busy");
    check_read(4'h0, "start_ctrl");
    core_pulse(16'h2D41, 16'h2D41);
    check_read(4'h8, "result");
    check_read(4'hC, "status_done");
  endtask

  task automatic test_busy_err;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, "start2");
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, "start_busy");
    check_read(4'hC, "status_err");
    core_pulse(16'h1234, 16'hFEDC);
    axi_write(4'hC, 32'h6, 4'hF, 0, 0, 0, "w1c");
    check_read(4'hC, "status_cleared");
  endtask

  task automatic test_backpressure;
    logic [31:0] e;
    logic st;
    int t;
    bready = 0;
    @(posedge clk); #1;
    awaddr = 4'h4; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    t = 0;
    while (!awready && t < 20) begin @(posedge clk); #1; t++; end
    model_write(4'h4, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, st);
    @(posedge clk); #1;
    wdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle=%0d bvalid=%b awready=%b required 1/0", i, bvalid, awready);
      end
      @(posedge clk); #1;
    end
    awvalid = 0; wvalid = 0; bready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (bvalid !== 1'b0) begin n_err++; $display("FAIL bp_release bvalid=%b required 0", bvalid); end
    check_read(4'h4, "bp_angle");
    e = model_read(4'h4);
    rready = 0;
    araddr = 4'h4; arvalid = 1;
    t = 0;
    while (!arready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    arvalid = 0;
    axi_write(4'h4, 32'h0BAD_CAFE, 4'hF, 0, 0, 0, "rp_wr");
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_err++;
        $display("FAIL rp_hold rvalid=%b rdata=%h required 1/%h", rvalid, rdata, e);
      end
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL rp_release rvalid=%b required 0", rvalid); end
    check_read(4'h4, "rp_angle");
  endtask

  task automatic test_simultaneous;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, "sim_start");
    axi_write(4'h0, 32'h1, 4'hF, 1, 16'h7001, 16'h8002, "sim_done_start");
    check_read(4'hC, "sim_status");
    check_read(4'h8, "sim_result");
    axi_write(4'hC, 32'h2, 4'hF, 1, 16'h0A0B, 16'h0C0D, "sim_w1c_set");
    check_read(4'hC, "sim_set_wins");
    axi_write(4'hC, 32'h6, 4'hF, 0, 0, 0, "sim_clear");
  endtask

  task automatic test_reset_mid;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, "mid_start");
    @(posedge clk); #1;
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    model_reset();
    core_pulse(16'h5555, 16'h6666);
    check_read(4'h8, "mid_result");
    check_read(4'hC, "mid_status");
  endtask

  task automatic test_random;
    logic [3:0] a;
    for (int k = 0; k < 60; k++) begin
      a = 4'($urandom_range(0, 3) * 4);
      case ($urandom_range(0, 3))
        0: axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom), "rnd_wr");
        1: core_pulse(16'($urandom), 16'($urandom));
        default: check_read(a, "rnd_rd");
      endcase
    end
  endtask

`ifdef CORDIC_IRQ_EN
  task automatic test_irq;
    axi_write(4'hC, 32'h6, 4'hF, 0, 0, 0, "irq_clr");
    axi_write(4'h0, 32'h5, 4'hF, 0, 0, 0, "irq_start");
    core_pulse(16'h1, 16'h2);
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set irq=%b required 1", irq); end
    axi_write(4'hC, 32'h2, 4'hF, 0, 0, 0, "irq_w1c");
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clr irq=%b required 0", irq); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_angle();
    test_start();
    test_busy_err();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef CORDIC_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cordic_axi_lite_slave.md
Name: cordic_axi_lite_slave

Overview:
AXI4-Lite slave register interface for the CORDIC IP. It terminates the transactions issued by the block-design AXI4-Lite master and exposes four 32-bit registers. It also drives a start/done handshake into the CORDIC datapath core and captures its sin/cos result. It sits between the AXI interconnect and the cordic core inside the IP wrapper.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, AXI address width; bits [3:2] select the register, bits [1:0] are ignored
RES_W, 16, width of each of core_sin and core_cos

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  synchronous reset, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte-lane strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response, always 2'b00
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response, always 2'b00
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
core_start  out  1  one-cycle start pulse to the CORDIC core
core_angle  out  32  ANGLE register contents
core_mode  out  1  CTRL.mode (0 = rotation, 1 = vectoring)
core_done  in  1  one-cycle completion pulse from the core
core_sin  in  RES_W  result, sampled on core_done
core_cos  in  RES_W  result, sampled on core_done

Behaviour:
- Reset (synchronous, S_AXI_ARESETN=0 at a clock edge) clears all outputs and registers to 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, core_start, CTRL, ANGLE, RESULT, STATUS. An in-flight core operation is abandoned; busy=0.
- Register map:
  - 0x0 CTRL RW: bit0 start (write-1 pulse, reads 0), bit1 mode, bit2 irq_en.
  - 0x4 ANGLE RW: all 32 bits, WSTRB applies per byte lane.
  - 0x8 RESULT RO: {sin[15:0], cos[15:0]}, sign-extended or truncated to 16 bits each if RES_W differs; writes ignored.
  - 0xC STATUS: bit0 busy RO, bit1 done W1C, bit2 err W1C; other bits read 0.
- Write channel:
  - AWREADY and WREADY are asserted together for exactly one cycle when AWVALID && WVALID && !AWREADY && !BVALID.
  - The register update happens on that handshake edge.
  - BVALID rises the next cycle and holds until BREADY; BRESP=OKAY.
  - Only one write is outstanding; AW-only or W-only is held off until both are valid.
- Read channel:
  - ARREADY is high for one cycle when ARVALID && !ARREADY && !RVALID.
  - RDATA is registered from the address latched at the handshake; RVALID rises the next cycle and holds, with RDATA stable, until RREADY.
  - Reads have no side effects.
- Start:
  - A CTRL write with WSTRB[0]=1 and WDATA[0]=1 while busy=0 produces core_start=1 on the cycle after the handshake and sets busy.
  - The same write with busy=1 produces no pulse and sets err.
- Completion:
  - core_done with busy=1 captures core_sin/core_cos into RESULT, clears busy, and sets done.
  - core_done with busy=0 is ignored.
- Simultaneous events:
  - A hardware set of done/err and a W1C clear on the same cycle: set wins.
  - core_done on the same cycle as a start write: completion is processed, and the start is accepted (busy ends at 1).
- Read and write handshakes are independent and may complete on the same cycle.

Optional Feature:
CORDIC_IRQ_EN:
- Defined: adds output port irq (1 bit), registered, equal to CTRL.irq_en && STATUS.done; reset 0; deasserts the cycle after done is cleared or irq_en is written 0.
- Undefined: no irq port; CTRL bit2 is still stored and read back.

Test Plan:
- After reset, read 0x0/0x4/0x8/0xC -> all return 0x00000000, RRESP=0; BVALID/RVALID are 0 out of reset.
- Write 0xDEAD0011 to 0x4 with WSTRB=4'b0011, then read 0x4 -> 0x00000011; core_angle=0x00000011.
- Write 0x3 to 0x0 -> core_start pulses one cycle after the handshake, core_mode=1, STATUS reads 0x1. Core returns done with sin=0x2D41, cos=0x2D41 -> RESULT=0x2D412D41, STATUS=0x2.
- Write 0x1 to 0x0 while busy -> no core_start, STATUS.err=1. Write 0x6 to 0xC -> STATUS=0x0.
- Hold BREADY=0 for 5 cycles after a write -> BVALID stays 1 and AWREADY stays 0 for a second AW/W. Hold RREADY=0 -> RDATA stable.
- Assert reset mid-operation (busy=1), then drive core_done -> RESULT stays 0 and STATUS=0. With CORDIC_IRQ_EN: irq_en=1 and done=1 -> irq=1; W1C done -> irq=0 the next cycle.
